// File: rtl/tap_vector_assembler_if.sv
// Handshake bundle for the tap vector assembler: serial sample input side
// and parallel seven-lane output side. The assembler uses the slave view.
interface tap_vector_assembler_if #(
  parameter int W = 12
);
  logic                in_valid;
  logic signed [W-1:0] in_sample;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] a_o;
  logic signed [W-1:0] b_o;
  logic signed [W-1:0] c_o;
  logic signed [W-1:0] d_o;
  logic signed [W-1:0] e_o;
  logic signed [W-1:0] f_o;
  logic signed [W-1:0] g_o;

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, a_o, b_o, c_o, d_o, e_o, f_o, g_o
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, a_o, b_o, c_o, d_o, e_o, f_o, g_o
  );
endinterface

// File: rtl/tap_vector_assembler.sv
// Collects seven consecutive signed samples into one parallel vector (a oldest,
// g newest), in block or sliding-window mode, with synchronous flush.
module tap_vector_assembler #(
  parameter int W     = 12,
  parameter int SLIDE = 0,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  tap_vector_assembler_if.slave bus,
  output logic [CNT_W-1:0]      vec_cnt
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e              state_q;
  logic [2:0]          fill_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic signed [W-1:0] lane_q [7];
  logic signed [W-1:0] lane_d [7];
  logic                accept;
  logic                emit;

  // While holding, input is only taken when the held vector leaves this cycle.
  assign bus.in_ready  = (state_q == S_FILL) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign emit          = out_valid_q && bus.out_ready;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      lane_d[i] = lane_q[i+1];
    end
    lane_d[6] = bus.in_sample;
    cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, emit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      fill_q      <= 3'd0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < 7; i++) lane_q[i] <= '0;
    end else if (flush) begin
      state_q     <= S_FILL;
      fill_q      <= 3'd0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 7; i++) lane_q[i] <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 7; i++) lane_q[i] <= lane_d[i];
      end
      cnt_q <= cnt_d;
      case (state_q)
        S_FILL: begin
          if (accept) begin
            fill_q <= fill_q + 3'd1;
            if (fill_q == 3'd6) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Sliding mode keeps the window; an emit without a new sample leaves it one short.
          if (emit) begin
            if (SLIDE == 0) begin
              state_q     <= S_FILL;
              out_valid_q <= 1'b0;
              fill_q      <= accept ? 3'd1 : 3'd0;
            end else if (!accept) begin
              state_q     <= S_FILL;
              out_valid_q <= 1'b0;
              fill_q      <= 3'd6;
            end
          end
        end
        default: begin
          state_q     <= S_FILL;
          out_valid_q <= 1'b0;
          fill_q      <= 3'd0;
        end
      endcase
    end
  end

  assign bus.a_o = lane_q[0];
  assign bus.b_o = lane_q[1];
  assign bus.c_o = lane_q[2];
  assign bus.d_o = lane_q[3];
  assign bus.e_o = lane_q[4];
  assign bus.f_o = lane_q[5];
  assign bus.g_o = lane_q[6];
  assign vec_cnt = cnt_q;

endmodule

// File: tb/tb_tap_vector_assembler.sv
// Bench for tap_vector_assembler: one block-mode and one sliding-mode instance
// checked by directed scenarios and a randomized run against a window model.
module tb_tap_vector_assembler;
  localparam int W     = 12;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_v = 1'b0;
  logic fl_v = 1'b0;
  logic iv [2];
  logic signed [W-1:0] smp [2];
  logic ord [2];
  logic [CNT_W-1:0] vc0, vc1;

  tap_vector_assembler_if #(.W(W)) if0 ();
  tap_vector_assembler_if #(.W(W)) if1 ();

  assign if0.in_valid = iv[0];
  assign if0.in_sample = smp[0];
  assign if0.out_ready = ord[0];
  assign if1.in_valid = iv[1];
  assign if1.in_sample = smp[1];
  assign if1.out_ready = ord[1];

  tap_vector_assembler #(.W(W), .SLIDE(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst_v), .flush(fl_v), .bus(if0), .vec_cnt(vc0));
  tap_vector_assembler #(.W(W), .SLIDE(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst_v), .flush(fl_v), .bus(if1), .vec_cnt(vc1));

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail = 0;

  // Reference model: window of the last seven accepted samples since restart,
  // a pending-vector flag, and how many more samples are needed for the next vector.
  logic [W-1:0] h0 [$];
  logic [W-1:0] h1 [$];
  bit pend [2];
  int need [2];
  int mcnt [2];

  function automatic logic [7*W-1:0] mlanes(int m);
    logic [7*W-1:0] r = '0;
    if (m == 0) foreach (h0[i]) r = {r[6*W-1:0], h0[i]};
    else        foreach (h1[i]) r = {r[6*W-1:0], h1[i]};
    return r;
  endfunction

  function automatic logic [7*W-1:0] seq7(int first, int step);
    logic [7*W-1:0] r = '0;
    int v;
    for (int i = 0; i < 7; i++) begin
      v = first + i * step;
      r = {r[6*W-1:0], v[W-1:0]};
    end
    return r;
  endfunction

  function automatic logic [7*W-1:0] obs_lanes(int m);
    if (m == 0) return {if0.a_o, if0.b_o, if0.c_o, if0.d_o, if0.e_o, if0.f_o, if0.g_o};
    return {if1.a_o, if1.b_o, if1.c_o, if1.d_o, if1.e_o, if1.f_o, if1.g_o};
  endfunction

  function automatic logic obs_vld(int m);
    return (m == 0) ? if0.out_valid : if1.out_valid;
  endfunction

  function automatic logic obs_rdy(int m);
    return (m == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  function automatic logic [CNT_W-1:0] obs_vc(int m);
    return (m == 0) ? vc0 : vc1;
  endfunction

  task automatic model_edge();
    bit rdy, acc, emt;
    for (int m = 0; m < 2; m++) begin
      rdy = !pend[m] || ord[m];
      acc = iv[m] && rdy;
      emt = pend[m] && ord[m];
      if (rst_v || fl_v) begin
        if (m == 0) h0.delete(); else h1.delete();
        pend[m] = 0;
        need[m] = 7;
        if (rst_v) mcnt[m] = 0;
      end else begin
        if (emt) begin
          mcnt[m] = (mcnt[m] + 1) % (1 << CNT_W);
          pend[m] = 0;
          need[m] = (m == 1) ? 1 : 7;
        end
        if (acc) begin
          if (m == 0) begin
            h0.push_back(smp[0]);
            if (h0.size() > 7) void'(h0.pop_front());
          end else begin
            h1.push_back(smp[1]);
            if (h1.size() > 7) void'(h1.pop_front());
          end
          need[m]--;
          if (need[m] == 0) pend[m] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drv(int m, bit v, int s, bit r);
    iv[m] = v;
    smp[m] = s[W-1:0];
    ord[m] = r;
    iv[1-m] = 1'b0;
    ord[1-m] = 1'b0;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0);
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      nchecks++; if (obs_vld(m) !== 1'b0) begin nfail++; $display("FAIL rst_valid dut%0d got=%b exp=0", m, obs_vld(m)); end
      nchecks++; if (obs_rdy(m) !== 1'b1) begin nfail++; $display("FAIL rst_ready dut%0d got=%b exp=1", m, obs_rdy(m)); end
      nchecks++; if (obs_lanes(m) !== '0) begin nfail++; $display("FAIL rst_lanes dut%0d got=%h exp=0", m, obs_lanes(m)); end
      nchecks++; if (obs_vc(m) !== '0) begin nfail++; $display("FAIL rst_cnt dut%0d got=%0d exp=0", m, obs_vc(m)); end
    end
  endtask

  task automatic test_block_fill();
    do_reset();
    for (int s = 1; s <= 7; s++) begin
      drv(0, 1, s, 1);
      tick();
      if (s == 6) begin
        nchecks++; if (obs_vld(0) !== 1'b0) begin nfail++; $display("FAIL blk_early_valid got=%b exp=0", obs_vld(0)); end
      end
    end
    nchecks++; if (obs_vld(0) !== 1'b1) begin nfail++; $display("FAIL blk_valid got=%b exp=1", obs_vld(0)); end
    nchecks++; if (obs_lanes(0) !== seq7(1, 1)) begin nfail++; $display("FAIL blk_lanes got=%h exp=%h", obs_lanes(0), seq7(1, 1)); end
    drv(0, 0, 0, 1);
    tick();
    nchecks++; if (obs_vld(0) !== 1'b0) begin nfail++; $display("FAIL blk_drop got=%b exp=0", obs_vld(0)); end
    nchecks++; if (obs_vc(0) !== 8'd1) begin nfail++; $display("FAIL blk_cnt got=%0d exp=1", obs_vc(0)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int s = 1; s <= 7; s++) begin
      drv(0, 1, -s, 0);
      tick();
    end
    drv(0, 1, -8, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      nchecks++; if (obs_rdy(0) !== 1'b0) begin nfail++; $display("FAIL bp_ready cyc%0d got=%b exp=0", k, obs_rdy(0)); end
      tick();
      nchecks++; if (obs_vld(0) !== 1'b1 || obs_lanes(0) !== seq7(-1, -1)) begin
        nfail++; $display("FAIL bp_hold cyc%0d got=%b/%h exp=1/%h", k, obs_vld(0), obs_lanes(0), seq7(-1, -1));
      end
    end
    drv(0, 1, -8, 1);
    tick();
    for (int s = 9; s <= 14; s++) begin
      drv(0, 1, -s, 1);
      tick();
    end
    nchecks++; if (obs_vld(0) !== 1'b1) begin nfail++; $display("FAIL bp_valid2 got=%b exp=1", obs_vld(0)); end
    nchecks++; if (obs_lanes(0) !== seq7(-8, -1)) begin nfail++; $display("FAIL bp_lanes2 got=%h exp=%h", obs_lanes(0), seq7(-8, -1)); end
    nchecks++; if (if0.g_o !== 12'hFF2) begin nfail++; $display("FAIL bp_sign got=%h exp=ff2", if0.g_o); end
    drv(0, 0, 0, 1);
    tick();
    nchecks++; if (obs_vc(0) !== 8'd2) begin nfail++; $display("FAIL bp_cnt got=%0d exp=2", obs_vc(0)); end
  endtask

  task automatic test_simul();
    do_reset();
    for (int s = 93; s <= 99; s++) begin
      drv(0, 1, s, 1);
      tick();
    end
    drv(0, 1, 100, 1);
    tick();
    nchecks++; if (obs_vld(0) !== 1'b0 || obs_vc(0) !== 8'd1) begin
      nfail++; $display("FAIL sim_emit got=%b/%0d exp=0/1", obs_vld(0), obs_vc(0));
    end
    for (int s = 101; s <= 106; s++) begin
      drv(0, 1, s, 0);
      tick();
    end
    nchecks++; if (obs_vld(0) !== 1'b1 || obs_lanes(0) !== seq7(100, 1)) begin
      nfail++; $display("FAIL sim_vec got=%b/%h exp=1/%h", obs_vld(0), obs_lanes(0), seq7(100, 1));
    end
  endtask

  task automatic test_sliding();
    do_reset();
    for (int s = 10; s <= 20; s++) begin
      drv(1, 1, s, 1);
      tick();
      if (s >= 16) begin
        nchecks++; if (obs_vld(1) !== 1'b1 || obs_lanes(1) !== seq7(s - 6, 1)) begin
          nfail++; $display("FAIL sl_vec s=%0d got=%b/%h exp=1/%h", s, obs_vld(1), obs_lanes(1), seq7(s - 6, 1));
        end
      end
    end
    drv(1, 0, 0, 1);
    tick();
    nchecks++; if (obs_vld(1) !== 1'b0 || obs_vc(1) !== 8'd5) begin
      nfail++; $display("FAIL sl_pause got=%b/%0d exp=0/5", obs_vld(1), obs_vc(1));
    end
    drv(1, 1, 21, 1);
    tick();
    nchecks++; if (obs_vld(1) !== 1'b1 || obs_lanes(1) !== seq7(15, 1)) begin
      nfail++; $display("FAIL sl_resume got=%b/%h exp=1/%h", obs_vld(1), obs_lanes(1), seq7(15, 1));
    end
    drv(1, 0, 0, 1);
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      drv(0, 1, s, 1);
      tick();
    end
    drv(0, 1, 99, 1);
    fl_v = 1'b1;
    tick();
    fl_v = 1'b0;
    nchecks++; if (obs_vld(0) !== 1'b0 || obs_lanes(0) !== '0) begin
      nfail++; $display("FAIL fl_mid got=%b/%h exp=0/0", obs_vld(0), obs_lanes(0));
    end
    for (int s = 31; s <= 37; s++) begin
      drv(0, 1, s, 0);
      tick();
    end
    nchecks++; if (obs_vld(0) !== 1'b1 || obs_lanes(0) !== seq7(31, 1)) begin
      nfail++; $display("FAIL fl_clean got=%b/%h exp=1/%h", obs_vld(0), obs_lanes(0), seq7(31, 1));
    end
    drv(0, 0, 0, 1);
    tick();
    for (int s = 41; s <= 47; s++) begin
      drv(0, 1, s, 0);
      tick();
    end
    drv(0, 1, 50, 1);
    fl_v = 1'b1;
    tick();
    fl_v = 1'b0;
    nchecks++; if (obs_vld(0) !== 1'b0 || obs_vc(0) !== 8'd1) begin
      nfail++; $display("FAIL fl_hold got=%b/%0d exp=0/1", obs_vld(0), obs_vc(0));
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] r;
    do_reset();
    for (int k = 0; k < 400 && mcnt[1] != 255; k++) begin
      r = $urandom;
      drv(1, 1, int'(r[W-1:0]), 1);
      tick();
    end
    nchecks++; if (obs_vc(1) !== 8'd255) begin nfail++; $display("FAIL wrap_255 got=%0d exp=255", obs_vc(1)); end
    tick();
    nchecks++; if (obs_vc(1) !== 8'd0) begin nfail++; $display("FAIL wrap_0 got=%0d exp=0", obs_vc(1)); end
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    drv(1, 0, 0, 0);
    #1;
    nchecks++; if (obs_vc(1) !== 8'd0 || obs_lanes(1) !== '0 || obs_vld(1) !== 1'b0) begin
      nfail++; $display("FAIL rst_hold got=%0d/%h/%b exp=0/0/0", obs_vc(1), obs_lanes(1), obs_vld(1));
    end
    nchecks++; if (obs_rdy(1) !== 1'b1) begin nfail++; $display("FAIL rst_hold_rdy got=%b exp=1", obs_rdy(1)); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      for (int k = 0; k < 500; k++) begin
        r = $urandom;
        drv(m, ($urandom_range(0, 3) != 0), int'(r[W-1:0]), ($urandom_range(0, 4) < 3));
        fl_v = ($urandom_range(0, 49) == 0);
        #1;
        nchecks++; if (obs_rdy(m) !== (!pend[m] || ord[m])) begin
          nfail++; $display("FAIL rnd_ready dut%0d cyc%0d got=%b exp=%b", m, k, obs_rdy(m), (!pend[m] || ord[m]));
        end
        tick();
        fl_v = 1'b0;
        nchecks++; if (obs_vld(m) !== pend[m] || obs_lanes(m) !== mlanes(m) || obs_vc(m) !== mcnt[m][CNT_W-1:0]) begin
          nfail++; $display("FAIL rnd_out dut%0d cyc%0d got=%b/%h/%0d exp=%b/%h/%0d", m, k,
                            obs_vld(m), obs_lanes(m), obs_vc(m), pend[m], mlanes(m), mcnt[m]);
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      iv[m] = 1'b0; smp[m] = '0; ord[m] = 1'b0;
      pend[m] = 0; need[m] = 7; mcnt[m] = 0;
    end
    #2;
    test_reset();
    test_block_fill();
    test_backpressure();
    test_simul();
    test_sliding();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule

// File: doc/tap_vector_assembler.md
Name: tap_vector_assembler

Overview:
- Write-side counterpart of the 7-lane half-rate sample holding register.
- Accepts a serial stream of signed W-bit samples over a valid/ready handshake.
- Assembles seven consecutive samples into one parallel vector, lanes a..g, and presents it to the downstream lane consumer with its own valid/ready handshake.
- Supports block (non-overlapping) and sliding-window assembly, plus a synchronous flush.

Parameters:
- W, 12: sample width in bits, two's complement signed.
- SLIDE, 0: 0 = block mode, one vector per 7 accepted samples; 1 = sliding mode, one vector per accepted sample once primed.
- CNT_W, 8: width of the emitted-vector counter.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst  in  1  Synchronous, active-high reset.
- flush  in  1  Synchronous restart: discards partial fill and any pending vector.
- in_valid  in  1  in_sample is valid this cycle.
- in_sample  in  W  Signed input sample.
- in_ready  out  1  Block accepts in_sample this cycle.
- out_valid  out  1  Lanes hold a complete vector.
- out_ready  in  1  Consumer takes the vector this cycle.
- a_o, b_o, c_o, d_o, e_o, f_o, g_o  out  W each  Signed lanes; a_o = oldest sample, g_o = newest.
- vec_cnt  out  CNT_W  Count of vectors consumed (out_valid && out_ready); wraps modulo 2^CNT_W.

Behaviour:
- Handshake rules:
  - Accept = in_valid && in_ready.
  - Emit = out_valid && out_ready.
  - Samples are never dropped or duplicated.
- Reset (rst=1 at edge):
  - All lanes 0, out_valid 0, vec_cnt 0, fill count 0, state FILL.
  - in_ready is 1 in the cycle after reset.
  - rst has priority over flush and over all handshakes.
- Flush (rst=0, flush=1):
  - Same as reset, except vec_cnt is retained.
  - Any accept or emit in the same cycle is ignored: the sample is lost, vec_cnt is not incremented.
- Storage and fill:
  - Storage is a 7-deep shift register. On accept, the lanes shift toward a (a<=b, ..., f<=g) and g<=in_sample.
  - Fill counter runs 0..7 and saturates at 7.
- State FILL:
  - out_valid=0, in_ready=1.
  - On accept, fill increments.
  - When the accept brings fill to 7, go to HOLD. out_valid=1 on the next cycle, so the vector appears 1 cycle after its 7th sample is accepted.
- State HOLD:
  - out_valid=1. Lanes must be stable until emit.
  - in_ready = out_ready (pass-through back-pressure, combinational from out_ready).
  - Block mode (SLIDE=0):
    - Emit without accept: fill<=0, go to FILL.
    - Emit with simultaneous accept: fill<=1, new sample shifted in, go to FILL.
  - Sliding mode (SLIDE=1):
    - Emit with accept: shift, fill stays 7, stay in HOLD (new vector next cycle, throughput 1 vector/cycle).
    - Emit without accept: go to FILL with fill=6 (window retained, one sample short). The next accept returns to HOLD.
- Stalls: with out_ready=0 in HOLD, in_ready=0 and the lanes stay frozen indefinitely.
- vec_cnt increments on every emit; 2^CNT_W-1 wraps to 0.
- Arithmetic: no arithmetic on samples. Lanes are bit-exact copies, and sign is preserved across all W bits.
- No combinational path from in_valid to out_valid. The only combinational paths are out_ready to in_ready, and the state-dependent constants.

Test Plan:
- Block fill: SLIDE=0, rst then samples 1,2,...,7 back-to-back, out_ready=1 → one cycle after the 7th accept, out_valid=1 with a_o..g_o = 1..7; next cycle out_valid=0; vec_cnt=1.
- Back-pressure: SLIDE=0, feed 14 samples (-1..-14) with out_ready=0 for 10 cycles after the first vector → lanes hold -1..-7, in_ready=0 throughout, no samples lost. After out_ready=1, the second vector is -8..-14 with full sign (0xFF8..0xFF2); vec_cnt=2.
- Simultaneous emit+accept: SLIDE=0, in HOLD with out_ready=1 and in_valid=1 sample 100 → emit occurs, fill=1. After 6 more samples (101..106), the vector is 100..106.
- Sliding mode: SLIDE=1, continuous samples 10..20 with out_ready=1 → first vector 10..16, then vectors every cycle: 11..17, 12..18, ..., 14..20. Pause input for 1 cycle → out_valid drops. Sample 21 → vector 15..21.
- Flush mid-fill and in HOLD: after 4 samples, assert flush → out_valid stays 0 and the next 7 samples form a clean vector. Flush in HOLD → out_valid=0 next cycle and vec_cnt is unchanged.
- Reset mid-operation and counter wrap: with CNT_W=8, emit 256 vectors → vec_cnt wraps 255→0. Assert rst during HOLD with out_ready=1 → no emit counted; all lanes 0, vec_cnt 0, in_ready=1 next cycle.
